// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative 32x32 radix-2 shift-add multiplier for RV32M
// (MUL, MULH, MULHSU, MULHU), using the ALU's level start/busy handshake.
// Operand magnitudes are multiplied, then one cycle applies the sign.
//
// Ports:
//   clock  - system clock, rising-edge active
//   reset  - synchronous active-high reset, aborts any operation
//   start  - level request, held by the ALU while a multiply op is selected
//   op     - 0=MUL (low word), 1=MULH (s x s), 2=MULHSU (s x u), 3=MULHU (u x u)
//   a, b   - multiplicand / multiplier
//   result - selected 32 bits of the product, held until next accept/reset
//   busy   - combinational stall: high while a result is pending
//   done   - one-cycle pulse when result becomes valid
//
// Optional feature macro: SEQ_MULTIPLIER_EARLY_EXIT_EN
//   When defined, a CALC cycle that finds the multiplier register already
//   zero goes straight to FIX, shortening latency for small |b|.
module seq_multiplier #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, HOLD} state_t;

  state_t              state, state_nxt;
  logic [XLEN-1:0]     a_lat, b_lat;
  logic [1:0]          op_lat;
  logic                neg;
  logic [2*XLEN-1:0]   mcand, prod;
  logic [XLEN-1:0]     mplier;
  logic [CW-1:0]       cnt;

  logic changed, accept, skip, calc_end, sign_a, sign_b;

  // Unsigned magnitude; 0x80000000 maps to itself, which is correct unsigned.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                 input logic neg_in);
    return neg_in ? -x : x;
  endfunction

  function automatic logic [2*XLEN-1:0] sign_fix(input logic [2*XLEN-1:0] p,
                                                 input logic neg_in);
    return neg_in ? -p : p;
  endfunction

  function automatic logic [XLEN-1:0] select_word(input logic [2*XLEN-1:0] p,
                                                  input logic [1:0] o);
    return (o == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  always_comb begin
    sign_a   = a[XLEN-1] & ((op == 2'd1) | (op == 2'd2));
    sign_b   = b[XLEN-1] & (op == 2'd1);
    changed  = (a != a_lat) || (b != b_lat) || (op != op_lat);
    accept   = start && ((state == IDLE) || ((state == HOLD) && changed));
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    skip     = (mplier == '0);
`else
    skip     = 1'b0;
`endif
    calc_end = skip || (cnt == LAST);

    busy      = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        busy = start;
        if (start) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (calc_end) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        // An unchanged held request is already answered; only a new one stalls.
        busy = start && changed;
        if (!start)       state_nxt = IDLE;
        else if (changed) state_nxt = CALC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      done   <= 1'b0;
      a_lat  <= '0;
      b_lat  <= '0;
      op_lat <= '0;
      neg    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (accept) begin
        a_lat  <= a;
        b_lat  <= b;
        op_lat <= op;
        neg    <= sign_a ^ sign_b;
        mcand  <= {{XLEN{1'b0}}, magnitude(a, sign_a)};
        mplier <= magnitude(b, sign_b);
        prod   <= '0;
        cnt    <= '0;
      end else if ((state == CALC) && !skip) begin
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end else if (state == FIX) begin
        result <= select_word(sign_fix(prod, neg), op_lat);
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed self-checking bench for seq_multiplier.
// A plain-arithmetic 64-bit product model predicts each result; a compare
// process checks result/done every cycle against the queue of expected
// results, and directed vectors also check literal values and busy lengths.
module tb_seq_multiplier;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        busy, done;

  int n_pass  = 0;
  int n_total = 0;
  bit armed   = 1'b0;
  logic [31:0] held = 32'h0;
  logic [31:0] exp_q[$];

  seq_multiplier #(.XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .result(result),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  task automatic check(input logic [63:0] act, input logic [63:0] exp,
                       input string name);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference product: sign- or zero-extend each operand to 64 bits and multiply.
  function automatic logic [31:0] model(input logic [1:0] o,
                                        input logic [31:0] x, input logic [31:0] y);
    longint xa, yb;
    logic [63:0] p;
    xa = (o == 2'd1 || o == 2'd2) ? longint'($signed(x)) : longint'(x);
    yb = (o == 2'd1) ? longint'($signed(y)) : longint'(y);
    p  = xa * yb;
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Busy cycles from request to result.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    logic [31:0] m;
    int k;
    m = (o == 2'd1 && y[31]) ? -y : y;
    if (m == 32'h0) return 3;
    k = 0;
    for (int i = 0; i < 32; i++) if (m[i]) k = i;
    return (k == 31) ? 34 : k + 4;
`else
    return (o == 2'd0 || y != 32'h0) ? 34 : 34;
`endif
  endfunction

  // Compare process: result must hold between done pulses and match the
  // model on each done; a done without an outstanding request is an error.
  always @(negedge clock) begin
    #2;
    if (armed) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done=1 expected done=0");
        end else begin
          held = exp_q.pop_front();
          check(result, held, "result_at_done");
        end
      end else begin
        check(result, held, "result_hold");
      end
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
      held = 32'h0;
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(o, x, y));
  endtask

  // Counts busy cycles from the current cycle until done is seen.
  task automatic wait_done(input int exp_busy, input string name);
    int  n = 0;
    int  guard = 0;
    bit  seen = 1'b0;
    while (!seen && guard < 200) begin
      #1;
      if (busy) n++;
      if (done) seen = 1'b1;
      else begin
        @(negedge clock);
        guard++;
      end
    end
    check(64'(seen), 64'd1, {name, "_done_seen"});
    check(64'(n), 64'(exp_busy), {name, "_busy_cycles"});
  endtask

  task automatic finish_op(input string name);
    @(negedge clock);
    #1;
    check(64'(busy), 64'd0, {name, "_hold_busy"});
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] lit, input string name);
    issue(o, x, y);
    wait_done(exp_lat(o, y), name);
    check(result, lit, {name, "_result"});
    finish_op(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'd0; a = 32'h0; b = 32'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    armed = 1'b1;
    #1;
    check(64'(busy), 64'd0, "reset_busy");
    check(64'(done), 64'd0, "reset_done");
    check(result, 32'h0, "reset_result");
    @(negedge clock);

    check(64'(model(2'd1, 32'h8000_0000, 32'h8000_0000)), 64'h4000_0000, "model_mulh");
    check(64'(model(2'd0, 32'd7, 32'hFFFF_FFFD)), 64'hFFFF_FFEB, "model_mul_neg");

    do_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ones");
    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ones");
    do_op(2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    do_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
    do_op(2'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
    do_op(2'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "mulh_7_m3");
    do_op(2'd0, 32'h1234_5678, 32'h0, 32'h0, "mul_b0");
    do_op(2'd0, 32'h1234_5678, 32'h1, 32'h1234_5678, "mul_b1");
    do_op(2'd3, 32'h2, 32'h8000_0000, 32'h0000_0001, "mulhu_msb");

    // Operand changes during CALC are ignored.
    issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(negedge clock);
    a = 32'd99;
    repeat (5) @(negedge clock);
    a = 32'hFFFF_FFFF;
    wait_done(exp_lat(2'd3, 32'hFFFF_FFFF) - 10, "mid_change");
    check(result, 32'hFFFF_FFFE, "mid_change_result");
    finish_op("mid_change");

    // Back-to-back: new operands in the cycle after done while start stays high.
    issue(2'd0, 32'd3, 32'd5);
    wait_done(exp_lat(2'd0, 32'd5), "b2b_first");
    check(result, 32'd15, "b2b_first_result");
    @(negedge clock);
    issue(2'd0, 32'd6, 32'd9);
    wait_done(exp_lat(2'd0, 32'd9), "b2b_second");
    check(result, 32'd54, "b2b_second_result");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check(64'(busy), 64'd0, "b2b_same_busy");
      check(64'(done), 64'd0, "b2b_same_done");
    end
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);

    // Reset on the 10th CALC edge aborts; a fresh request then completes.
    issue(2'd0, 32'h1234, 32'h8000_0010);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check(64'(busy), 64'd1, "post_reset_busy");
    check(64'(done), 64'd0, "post_reset_done");
    check(result, 32'h0, "post_reset_result");
    issue(2'd0, 32'h1234, 32'h8000_0010);
    wait_done(exp_lat(2'd0, 32'h8000_0010), "after_reset");
    check(result, 32'h0001_2340, "after_reset_result");
    finish_op("after_reset");

    repeat (2) @(negedge clock);
    check(64'(exp_q.size()), 64'd0, "queue_drained");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
